// File: rtl/cache_wb_param.sv
// Direct-mapped write-back data cache with a per-line dirty bit. It uses
// write-allocate on misses. The requester side and the word-wide memory side
// each use a req/ready style handshake, and memory latency may vary.
module cache_wb_param #(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned LINE_BITS = 2,
  parameter int unsigned BLK_BITS  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              hit,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned TAG_W     = ADDR_W - LINE_BITS - BLK_BITS;
  localparam int unsigned IDX_W     = LINE_BITS + BLK_BITS;
  localparam int unsigned NUM_LINES = 1 << LINE_BITS;
  localparam int unsigned NUM_WORDS = 1 << IDX_W;

  typedef enum logic [1:0] {StIdle, StLookup, StWb, StRefill} state_e;

  state_e                state_q;
  logic [NUM_LINES-1:0]  valid_q;
  logic [NUM_LINES-1:0]  dirty_q;
  logic [BLK_BITS-1:0]   cnt_q;
  logic                  first_try_q;
  logic                  acc_we_q;
  logic [ADDR_W-1:0]     acc_addr_q;
  logic [DATA_W-1:0]     acc_wdata_q;

  logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
  logic [DATA_W-1:0]     data_mem [NUM_WORDS];

  logic [TAG_W-1:0]      acc_tag;
  logic [LINE_BITS-1:0]  acc_line;
  logic [BLK_BITS-1:0]   acc_blk;
  logic [IDX_W-1:0]      acc_idx;
  logic [IDX_W-1:0]      cnt_idx;
  logic                  lookup_hit;
  logic                  last_word;

  // Field decode of the captured access and the hit test
  always_comb begin
    acc_tag    = acc_addr_q[ADDR_W-1 -: TAG_W];
    acc_line   = acc_addr_q[BLK_BITS +: LINE_BITS];
    acc_blk    = acc_addr_q[BLK_BITS-1:0];
    acc_idx    = {acc_line, acc_blk};
    cnt_idx    = {acc_line, cnt_q};
    lookup_hit = valid_q[acc_line] && (tag_mem[acc_line] == acc_tag);
    last_word  = (cnt_q == {BLK_BITS{1'b1}});
  end

  // Output decode; depends only on state and stored values, never on req
  always_comb begin
    busy      = (state_q != StIdle);
    ready     = (state_q == StLookup) && lookup_hit;
    hit       = ready && first_try_q;
    rdata     = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ready && !acc_we_q) begin
      rdata = data_mem[acc_idx];
    end
    unique case (state_q)
      StWb: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_mem[acc_line], acc_line, cnt_q};
        mem_wdata = data_mem[cnt_idx];
      end
      StRefill: begin
        mem_req  = 1'b1;
        mem_addr = {acc_tag, acc_line, cnt_q};
      end
      default: ;
    endcase
  end

  // Control FSM, line status bits and access capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      dirty_q     <= '0;
      cnt_q       <= '0;
      first_try_q <= 1'b0;
      acc_we_q    <= 1'b0;
      acc_addr_q  <= '0;
      acc_wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            acc_we_q    <= we;
            acc_addr_q  <= address;
            acc_wdata_q <= wdata;
            first_try_q <= 1'b1;
            state_q     <= StLookup;
          end
        end
        StLookup: begin
          if (lookup_hit) begin
            if (acc_we_q) begin
              dirty_q[acc_line] <= 1'b1;
            end
            state_q <= StIdle;
          end else begin
            cnt_q       <= '0;
            first_try_q <= 1'b0;
            if (valid_q[acc_line] && dirty_q[acc_line]) begin
              state_q <= StWb;
            end else begin
              // Line is overwritten word by word, so it must not look valid meanwhile
              valid_q[acc_line] <= 1'b0;
              state_q           <= StRefill;
            end
          end
        end
        StWb: begin
          if (mem_ack) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_word) begin
              dirty_q[acc_line] <= 1'b0;
              valid_q[acc_line] <= 1'b0;
              state_q           <= StRefill;
            end
          end
        end
        StRefill: begin
          if (mem_ack) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_word) begin
              valid_q[acc_line] <= 1'b1;
              dirty_q[acc_line] <= 1'b0;
              state_q           <= StLookup;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag and data arrays; no reset, contents are guarded by the valid bits
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == StRefill && mem_ack) begin
        data_mem[cnt_idx] <= mem_rdata;
        if (last_word) begin
          tag_mem[acc_line] <= acc_tag;
        end
      end
      if (state_q == StLookup && lookup_hit && acc_we_q) begin
        data_mem[acc_idx] <= acc_wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_cache_wb_param.sv
// Self-checking bench for cache_wb_param: scoreboard queues hold the expected
// completions and memory word transfers; a monitor pops them as they occur.
module tb_cache_wb_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [10:0] address;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        ready;
  logic        hit;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  typedef struct {
    logic       chk;
    logic [7:0] rdata;
    logic       hit;
  } rd_exp_t;

  typedef struct {
    logic        we;
    logic [10:0] addr;
    logic [7:0]  wdata;
  } mem_exp_t;

  rd_exp_t  rd_q[$];
  mem_exp_t mem_q[$];

  int tests = 0;
  int fails = 0;

  logic        prev_pend = 1'b0;
  logic [10:0] prev_addr = '0;
  logic        prev_we   = 1'b0;

  always #5 clk = ~clk;

  // Backing memory returns the low byte of the requested word address
  assign mem_rdata = mem_addr[7:0];

  cache_wb_param #(
    .ADDR_W   (11),
    .DATA_W   (8),
    .LINE_BITS(2),
    .BLK_BITS (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .we       (we),
    .address  (address),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .hit      (hit),
    .busy     (busy),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  // Monitor: compare completions and memory transfers against the scoreboard
  initial begin
    forever begin : mon
      rd_exp_t  re;
      mem_exp_t me;
      @(negedge clk);
      if (reset) begin
        prev_pend = 1'b0;
      end else begin
        if (ready) begin
          tests++;
          if (rd_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_ready: got ready=1 addr=%h want no completion",
                     dut.acc_addr_q);
          end else begin
            re = rd_q.pop_front();
            if (hit !== re.hit) begin
              fails++;
              $display("FAIL ready_hit: got %b want %b", hit, re.hit);
            end
            if (re.chk) begin
              tests++;
              if (rdata !== re.rdata) begin
                fails++;
                $display("FAIL ready_rdata: got %h want %h", rdata, re.rdata);
              end
            end
          end
        end
        if (prev_pend) begin
          tests++;
          if (mem_req !== 1'b1 || mem_addr !== prev_addr || mem_we !== prev_we) begin
            fails++;
            $display("FAIL mem_hold: got req=%b addr=%h we=%b want req=1 addr=%h we=%b",
                     mem_req, mem_addr, mem_we, prev_addr, prev_we);
          end
        end
        if (mem_req === 1'b1 && mem_ack === 1'b1) begin
          tests++;
          if (mem_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_mem_xfer: got addr=%h we=%b want none", mem_addr, mem_we);
          end else begin
            me = mem_q.pop_front();
            if (mem_we !== me.we || mem_addr !== me.addr) begin
              fails++;
              $display("FAIL mem_xfer: got we=%b addr=%h want we=%b addr=%h",
                       mem_we, mem_addr, me.we, me.addr);
            end
            if (me.we) begin
              tests++;
              if (mem_wdata !== me.wdata) begin
                fails++;
                $display("FAIL mem_wdata: got %h want %h at addr %h",
                         mem_wdata, me.wdata, me.addr);
              end
            end
          end
        end
        prev_pend = mem_req && !mem_ack;
        prev_addr = mem_addr;
        prev_we   = mem_we;
      end
    end
  end

  task automatic push_rd(input logic chk, input logic [7:0] rd, input logic h);
    rd_exp_t e;
    e.chk = chk; e.rdata = rd; e.hit = h;
    rd_q.push_back(e);
  endtask

  // Expect a full line of transfers starting at base; word sp carries value sv on write-back
  task automatic push_line(input logic w, input logic [10:0] base, input int n,
                           input int sp, input logic [7:0] sv);
    mem_exp_t e;
    for (int i = 0; i < n; i++) begin
      e.we    = w;
      e.addr  = base + 11'(i);
      e.wdata = (i == sp) ? sv : e.addr[7:0];
      mem_q.push_back(e);
    end
  endtask

  // One access; ack every per cycles; optional stray req at cycle poke
  task automatic access(input logic w, input logic [10:0] a, input logic [7:0] d,
                        input int per, input int poke,
                        output int lat, output int last_ack, output int n_req);
    int cyc = 0;
    lat = -1; last_ack = -1; n_req = 0;
    @(posedge clk); #1;
    req = 1'b1; we = w; address = a; wdata = d;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1 || cyc == poke + 1) req = 1'b0;
      if (cyc == poke) begin
        req = 1'b1; we = 1'b1; address = 11'h7FF; wdata = 8'hEE;
      end
      if (ready) begin
        lat = cyc;
        break;
      end
      if (mem_req) n_req++;
      mem_ack = (cyc % per == 0);
      if (mem_req && mem_ack) last_ack = cyc;
      if (cyc >= 300) begin
        tests++; fails++;
        $display("FAIL access_timeout: got no ready after %0d cycles want ready", cyc);
        break;
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests++; if (ready !== 1'b0)     begin fails++; $display("FAIL rst_ready: got %b want 0", ready); end
    tests++; if (hit !== 1'b0)       begin fails++; $display("FAIL rst_hit: got %b want 0", hit); end
    tests++; if (mem_req !== 1'b0)   begin fails++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    tests++; if (mem_we !== 1'b0)    begin fails++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    tests++; if (rdata !== 8'h00)    begin fails++; $display("FAIL rst_rdata: got %h want 00", rdata); end
    tests++; if (mem_addr !== 11'h0) begin fails++; $display("FAIL rst_mem_addr: got %h want 000", mem_addr); end
    tests++; if (mem_wdata !== 8'h0) begin fails++; $display("FAIL rst_mem_wdata: got %h want 00", mem_wdata); end
    reset = 1'b0;
  endtask

  task automatic test_read_miss_clean;
    int lat, la, nr;
    push_line(1'b0, 11'h010, 8, -1, 8'h00);
    push_rd(1'b1, 8'h15, 1'b0);
    access(1'b0, 11'h015, 8'h00, 1, -10, lat, la, nr);
    tests++; if (lat !== 10) begin fails++; $display("FAIL clean_miss_latency: got %0d want 10", lat); end
  endtask

  task automatic test_read_hit;
    int lat, la, nr;
    push_rd(1'b1, 8'h12, 1'b1);
    access(1'b0, 11'h012, 8'h00, 1, -10, lat, la, nr);
    tests++; if (lat !== 1) begin fails++; $display("FAIL hit_latency: got %0d want 1", lat); end
    tests++; if (nr !== 0)  begin fails++; $display("FAIL hit_mem_req: got %0d cycles want 0", nr); end
  endtask

  task automatic test_write_hit;
    int lat, la, nr;
    push_rd(1'b0, 8'h00, 1'b1);
    access(1'b1, 11'h013, 8'hAA, 1, -10, lat, la, nr);
    tests++; if (lat !== 1) begin fails++; $display("FAIL write_hit_latency: got %0d want 1", lat); end
  endtask

  task automatic test_dirty_evict;
    int lat, la, nr;
    push_line(1'b1, 11'h010, 8, 3, 8'hAA);
    push_line(1'b0, 11'h410, 8, -1, 8'h00);
    push_rd(1'b1, 8'h13, 1'b0);
    access(1'b0, 11'h413, 8'h00, 1, -10, lat, la, nr);
    tests++; if (lat !== 18) begin fails++; $display("FAIL dirty_miss_latency: got %0d want 18", lat); end
  endtask

  task automatic test_stall;
    int lat, la, nr;
    push_line(1'b0, 11'h028, 8, -1, 8'h00);
    push_rd(1'b1, 8'h2B, 1'b0);
    access(1'b0, 11'h02B, 8'h00, 3, -10, lat, la, nr);
    tests++; if (lat !== la + 1) begin fails++; $display("FAIL stall_ready: got cycle %0d want %0d", lat, la + 1); end
    tests++; if (mem_q.size() !== 0) begin fails++; $display("FAIL stall_words: got %0d left want 0", mem_q.size()); end
    push_rd(1'b1, 8'h2F, 1'b1);
    access(1'b0, 11'h02F, 8'h00, 1, -10, lat, la, nr);
    tests++; if (lat !== 1) begin fails++; $display("FAIL stall_rehit: got %0d want 1", lat); end
  endtask

  task automatic test_reset_mid_refill;
    int n = 0;
    int cyc = 0;
    int lat, la, nr;
    push_line(1'b0, 11'h058, 4, -1, 8'h00);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; address = 11'h05C; mem_ack = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) req = 1'b0;
      if (n == 4) begin
        reset = 1'b1; mem_ack = 1'b0;
        break;
      end
      if (mem_req && mem_ack) n++;
      if (cyc >= 100) begin
        tests++; fails++;
        $display("FAIL midrst_timeout: got %0d acks want 4", n);
        break;
      end
    end
    @(posedge clk); #1;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL midrst_mem_req: got %b want 0", mem_req); end
    tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
    reset = 1'b0;
    push_line(1'b0, 11'h058, 8, -1, 8'h00);
    push_rd(1'b1, 8'h5C, 1'b0);
    access(1'b0, 11'h05C, 8'h00, 1, -10, lat, la, nr);
    tests++; if (lat !== 10) begin fails++; $display("FAIL midrst_reread: got %0d want 10", lat); end
  endtask

  task automatic test_req_while_busy;
    int lat, la, nr;
    push_line(1'b0, 11'h000, 8, -1, 8'h00);
    push_rd(1'b0, 8'h00, 1'b0);
    access(1'b1, 11'h005, 8'h5A, 1, -10, lat, la, nr);
    tests++; if (lat !== 10) begin fails++; $display("FAIL write_miss_latency: got %0d want 10", lat); end
    push_line(1'b1, 11'h000, 8, 5, 8'h5A);
    push_line(1'b0, 11'h400, 8, -1, 8'h00);
    push_rd(1'b1, 8'h05, 1'b0);
    access(1'b0, 11'h405, 8'h00, 1, 4, lat, la, nr);
    tests++; if (lat !== 18) begin fails++; $display("FAIL busy_req_latency: got %0d want 18", lat); end
    repeat (6) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_req_idle: got %b want 0", busy); end
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; address = '0; wdata = '0; mem_ack = 1'b0;
    test_reset;
    test_read_miss_clean;
    test_read_hit;
    test_write_hit;
    test_dirty_evict;
    test_stall;
    test_reset_mid_refill;
    test_req_while_busy;
    tests++;
    if (rd_q.size() != 0 || mem_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d completions %0d transfers pending want 0 0",
               rd_q.size(), mem_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
